i2c_poll_seq: RTL and testbench

Periodic sensor-poll sequencer that sits directly upstream of the I2C master interface (`i2c_m_if`) and drives its command port. Each poll issues one write (command) transaction, waits a programmable conversion time, issues one read transaction, and publishes the returned data word with a one-cycle valid strobe plus sample counter and sticky error flags. It lets the room-entry logic consume sensor samples without sequencing the bus itself.

---
 rtl/i2c_poll_seq.sv | 177 +++++++++++++++++
 tb/tb_i2c_poll_seq.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_poll_seq.sv
// Periodic sensor-poll sequencer: write command, wait conversion, read sample,
// publish word with a valid strobe. Drives the i2c_m_if command port.
module i2c_poll_seq #(
  parameter logic [6:0]  DEV_ADR     = 7'h44,
  parameter logic [31:0] CMD_DATA    = 32'h2400_0000,
  parameter logic [2:0]  CMD_BYTES   = 3'd2,
  parameter logic [2:0]  RD_BYTES    = 3'd4,
  parameter logic [23:0] POLL_PERIOD = 24'd5_000_000,
  parameter logic [19:0] CONV_WAIT   = 20'd1_000_000,
  parameter logic [7:0]  REQ_TMO     = 8'd64
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        enable,
  input  logic        trig,
  input  logic        err_clr,
  output logic [6:0]  m_adr,
  output logic        m_wr,
  output logic        m_rd,
  output logic [31:0] m_wr_data,
  output logic [2:0]  m_wr_bytes,
  output logic [2:0]  m_rd_bytes,
  input  logic        m_busy,
  input  logic [31:0] m_rd_data,
  input  logic        m_rd_data_en,
  output logic [31:0] result,
  output logic        result_valid,
  output logic [15:0] sample_cnt,
  output logic        err_tmo,
  output logic        err_nodata,
  output logic        seq_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_BUSY, S_CONV, S_RD_REQ, S_RD_BUSY, S_DONE
  } state_t;

  localparam logic [23:0] POLL_LAST = POLL_PERIOD - 24'd1;
  localparam logic [19:0] CONV_LAST = CONV_WAIT - 20'd1;
  localparam logic [7:0]  TMO_LAST  = REQ_TMO - 8'd1;

  state_t      r_state, w_state_next;
  logic [23:0] r_timer, w_timer_next;
  logic [19:0] r_conv, w_conv_next;
  logic [7:0]  r_wd, w_wd_next;
  logic        r_got, w_got_next;
  logic [31:0] r_cap, w_cap_next;
  logic        w_set_tmo, w_set_nodata;

  logic        r_m_wr, r_m_rd, r_result_valid, r_err_tmo, r_err_nodata;
  logic [31:0] r_result;
  logic [15:0] r_sample_cnt;

  always_comb begin
    w_state_next = r_state;
    w_timer_next = '0;
    w_conv_next  = r_conv;
    w_wd_next    = r_wd;
    w_got_next   = r_got;
    w_cap_next   = r_cap;
    w_set_tmo    = 1'b0;
    w_set_nodata = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_wd_next = '0;
        if (trig) begin
          w_state_next = S_WR_REQ;
        end else if (enable) begin
          if (r_timer == POLL_LAST) w_state_next = S_WR_REQ;
          else                      w_timer_next = r_timer + 24'd1;
        end
      end
      S_WR_REQ: begin
        if (m_busy) begin
          w_state_next = S_WR_BUSY;
          w_wd_next    = '0;
        end else if (r_wd == TMO_LAST) begin
          w_state_next = S_IDLE;
          w_set_tmo    = 1'b1;
          w_wd_next    = '0;
        end else begin
          w_wd_next = r_wd + 8'd1;
        end
      end
      S_WR_BUSY: begin
        if (!m_busy) begin
          w_state_next = S_CONV;
          w_conv_next  = '0;
        end
      end
      S_CONV: begin
        if (r_conv == CONV_LAST) w_state_next = S_RD_REQ;
        else                     w_conv_next  = r_conv + 20'd1;
      end
      S_RD_REQ: begin
        w_got_next = 1'b0;
        if (m_busy) begin
          w_state_next = S_RD_BUSY;
          w_wd_next    = '0;
        end else if (r_wd == TMO_LAST) begin
          w_state_next = S_IDLE;
          w_set_tmo    = 1'b1;
          w_wd_next    = '0;
        end else begin
          w_wd_next = r_wd + 8'd1;
        end
      end
      S_RD_BUSY: begin
        // Data strobe coinciding with busy falling still counts as a good read.
        if (m_rd_data_en) begin
          w_got_next = 1'b1;
          w_cap_next = m_rd_data;
        end
        if (!m_busy) begin
          if (w_got_next) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_IDLE;
            w_set_nodata = 1'b1;
          end
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state        <= S_IDLE;
      r_timer        <= '0;
      r_conv         <= '0;
      r_wd           <= '0;
      r_got          <= 1'b0;
      r_cap          <= '0;
      r_m_wr         <= 1'b0;
      r_m_rd         <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_sample_cnt   <= '0;
      r_err_tmo      <= 1'b0;
      r_err_nodata   <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_timer        <= w_timer_next;
      r_conv         <= w_conv_next;
      r_wd           <= w_wd_next;
      r_got          <= w_got_next;
      r_cap          <= w_cap_next;
      r_m_wr         <= (w_state_next == S_WR_REQ);
      r_m_rd         <= (w_state_next == S_RD_REQ);
      r_result_valid <= (w_state_next == S_DONE);
      if (w_state_next == S_DONE) begin
        r_result     <= w_cap_next;
        r_sample_cnt <= r_sample_cnt + 16'd1;
      end
      if (w_set_tmo)    r_err_tmo <= 1'b1;
      else if (err_clr) r_err_tmo <= 1'b0;
      if (w_set_nodata) r_err_nodata <= 1'b1;
      else if (err_clr) r_err_nodata <= 1'b0;
    end
  end

  assign m_adr        = DEV_ADR;
  assign m_wr_data    = CMD_DATA;
  assign m_wr_bytes   = CMD_BYTES;
  assign m_rd_bytes   = RD_BYTES;
  assign m_wr         = r_m_wr;
  assign m_rd         = r_m_rd;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign sample_cnt   = r_sample_cnt;
  assign err_tmo      = r_err_tmo;
  assign err_nodata   = r_err_nodata;
  assign seq_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_i2c_poll_seq.sv
// Bench for i2c_poll_seq: behavioural master model, event-level reference
// model checked every cycle, plus directed literal checks per scenario.
module tb_i2c_poll_seq;
  localparam int P        = 100;
  localparam int CW       = 20;
  localparam int TMO      = 16;
  localparam int BUSY_LEN = 40;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        enable = 1'b0, trig = 1'b0, err_clr = 1'b0;
  logic        m_busy = 1'b0, m_rd_data_en = 1'b0;
  logic [31:0] m_rd_data = 32'h5A5A_5A5A;
  logic [6:0]  m_adr;
  logic        m_wr, m_rd, result_valid, err_tmo, err_nodata, seq_busy;
  logic [31:0] m_wr_data, result;
  logic [2:0]  m_wr_bytes, m_rd_bytes;
  logic [15:0] sample_cnt;

  int vecs = 0, miss = 0, cyc = 0;

  always #5 clk = ~clk;

  i2c_poll_seq #(
    .POLL_PERIOD(24'd100), .CONV_WAIT(20'd20), .REQ_TMO(8'd16)
  ) dut (
    .clk(clk), .rstb(rstb), .enable(enable), .trig(trig), .err_clr(err_clr),
    .m_adr(m_adr), .m_wr(m_wr), .m_rd(m_rd), .m_wr_data(m_wr_data),
    .m_wr_bytes(m_wr_bytes), .m_rd_bytes(m_rd_bytes), .m_busy(m_busy),
    .m_rd_data(m_rd_data), .m_rd_data_en(m_rd_data_en), .result(result),
    .result_valid(result_valid), .sample_cnt(sample_cnt), .err_tmo(err_tmo),
    .err_nodata(err_nodata), .seq_busy(seq_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Master: busy one cycle after a request edge, 40 cycles long, read data
  // strobed in the last busy cycle.
  logic        mst_dead = 1'b0, mst_nodata = 1'b0;
  logic [31:0] mst_word = 32'hA1B2_C3D4;
  initial begin : master
    int bcnt;
    bit pend, pend_rd, cur_rd, wr_prev, rd_prev;
    bcnt = 0; pend = 0; pend_rd = 0; cur_rd = 0; wr_prev = 0; rd_prev = 0;
    forever begin
      @(posedge clk); #1;
      m_rd_data_en = 1'b0;
      m_rd_data    = 32'h5A5A_5A5A;
      if (!rstb) begin
        bcnt = 0; pend = 0; m_busy = 1'b0; wr_prev = 0; rd_prev = 0;
      end else begin
        if (bcnt != 0) begin
          bcnt--;
          if (bcnt == 0) m_busy = 1'b0;
          else if (bcnt == 1 && cur_rd && !mst_nodata) begin
            m_rd_data_en = 1'b1;
            m_rd_data    = mst_word;
          end
        end else if (pend) begin
          pend = 0;
          if (!mst_dead) begin
            m_busy = 1'b1; bcnt = BUSY_LEN; cur_rd = pend_rd;
          end
        end
        if (m_wr && !wr_prev) begin pend = 1; pend_rd = 0; end
        if (m_rd && !rd_prev) begin pend = 1; pend_rd = 1; end
        wr_prev = m_wr; rd_prev = m_rd;
      end
    end
  end

  // Reference model: phases of a poll as seen from the bus, with deadlines.
  int          ph = 0, idle_run = 0, req_age = 0, rd_at = 0;
  bit          got = 0;
  logic [31:0] cap = '0;
  logic        e_wr = 0, e_rd = 0, e_busy = 0, e_valid = 0, e_tmo = 0, e_nodata = 0;
  logic [31:0] e_result = '0;
  logic [15:0] e_cnt = '0;
  int          wr_rises = 0, rd_rises = 0, valids = 0, wr_rise_cyc = 0, rd_rise_cyc = 0;
  int          wr_fall_cyc = 0, wr_run = 0, wr_len = 0, idle_gap = 0, last_gap = 0, trig_cyc = 0;
  logic        prev_wr = 0, prev_rd = 0;

  always @(negedge clk) begin : model
    bit set_t, set_n;
    cyc++;
    if (!rstb) begin
      ph = 0; idle_run = 0; got = 0; req_age = 0;
      e_wr = 0; e_rd = 0; e_busy = 0; e_valid = 0; e_tmo = 0; e_nodata = 0;
      e_result = '0; e_cnt = '0; prev_wr = 0; prev_rd = 0; wr_run = 0;
    end else begin
      chk("m_wr", 32'(m_wr), 32'(e_wr));
      chk("m_rd", 32'(m_rd), 32'(e_rd));
      chk("seq_busy", 32'(seq_busy), 32'(e_busy));
      chk("result_valid", 32'(result_valid), 32'(e_valid));
      chk("result", result, e_result);
      chk("sample_cnt", 32'(sample_cnt), 32'(e_cnt));
      chk("err_tmo", 32'(err_tmo), 32'(e_tmo));
      chk("err_nodata", 32'(err_nodata), 32'(e_nodata));
      if (!seq_busy) idle_gap++;
      if (m_wr && !prev_wr) begin
        wr_rises++; wr_rise_cyc = cyc; last_gap = idle_gap; idle_gap = 0;
      end
      if (m_rd && !prev_rd) begin rd_rises++; rd_rise_cyc = cyc; end
      if (m_wr) wr_run++;
      else if (prev_wr) begin wr_len = wr_run; wr_run = 0; end
      if (result_valid) begin
        valids++;
        $display("txn %0d: result=%h sample_cnt=%0d", valids, result, sample_cnt);
      end
      prev_wr = m_wr; prev_rd = m_rd;

      set_t = 0; set_n = 0;
      case (ph)
        0: if (trig || (enable && idle_run == P - 1)) begin
             ph = 1; req_age = 0; idle_run = 0;
           end else idle_run = enable ? idle_run + 1 : 0;
        1: if (m_busy) ph = 2;
           else if (req_age == TMO - 1) begin ph = 0; set_t = 1; end
           else req_age++;
        2: if (!m_busy) begin ph = 3; rd_at = cyc + 1 + CW; wr_fall_cyc = cyc; end
        3: if (cyc + 1 == rd_at) begin ph = 4; req_age = 0; got = 0; end
        4: if (m_busy) ph = 5;
           else if (req_age == TMO - 1) begin ph = 0; set_t = 1; end
           else req_age++;
        5: begin
             if (m_rd_data_en) begin got = 1; cap = m_rd_data; end
             if (!m_busy) begin
               if (got) begin ph = 6; e_result = cap; e_cnt = e_cnt + 16'd1; end
               else begin ph = 0; set_n = 1; end
             end
           end
        default: ph = 0;
      endcase
      e_valid = (ph == 6);
      e_busy  = (ph != 0);
      e_wr    = (ph == 1);
      e_rd    = (ph == 4);
      if (set_t) e_tmo = 1; else if (err_clr) e_tmo = 0;
      if (set_n) e_nodata = 1; else if (err_clr) e_nodata = 0;
    end
  end

  task automatic pulse_trig();
    @(posedge clk); #1;
    trig = 1'b1; trig_cyc = cyc + 1;
    @(posedge clk); #1;
    trig = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1; err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (!seq_busy) break;
    end
    chk({name, "_idle_bound"}, 32'(i < 600), 32'd1);
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int v0, r0, rr0, i;
    repeat (3) @(posedge clk); #1;
    rstb = 1'b1;
    settle();
    chk("rst_m_wr", 32'(m_wr), 32'd0);
    chk("rst_m_rd", 32'(m_rd), 32'd0);
    chk("rst_seq_busy", 32'(seq_busy), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_cnt", 32'(sample_cnt), 32'd0);
    chk("rst_errs", 32'({err_tmo, err_nodata}), 32'd0);
    chk("m_adr", 32'(m_adr), 32'h44);
    chk("m_wr_data", m_wr_data, 32'h2400_0000);
    chk("m_bytes", 32'({m_wr_bytes, m_rd_bytes}), 32'o24);

    // Single manual poll
    mst_word = 32'hA1B2_C3D4;
    pulse_trig();
    wait_idle("t1");
    settle();
    chk("t1_wr_latency", wr_rise_cyc - trig_cyc, 1);
    chk("t1_wr_len", wr_len, 2);
    chk("t1_conv_gap", rd_rise_cyc - wr_fall_cyc, CW + 1);
    chk("t1_result", result, 32'hA1B2_C3D4);
    chk("t1_cnt", 32'(sample_cnt), 32'd1);
    chk("t1_valids", valids, 1);

    // Five periodic polls
    mst_word = 32'h1234_5678;
    v0 = valids;
    @(posedge clk); #1; enable = 1'b1;
    for (i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (valids >= v0 + 5) break;
    end
    enable = 1'b0;
    chk("t2_poll_bound", 32'(i < 3000), 32'd1);
    settle();
    chk("t2_valids", valids - v0, 5);
    chk("t2_cnt", 32'(sample_cnt), 32'd6);
    chk("t2_result", result, 32'h1234_5678);
    chk("t2_gap", last_gap, P);

    // Request never acknowledged
    mst_dead = 1'b1;
    pulse_trig();
    wait_idle("t3");
    settle();
    chk("t3_wr_len", wr_len, TMO);
    chk("t3_err_tmo", 32'(err_tmo), 32'd1);
    chk("t3_seq_busy", 32'(seq_busy), 32'd0);
    mst_dead = 1'b0;
    pulse_clr();
    settle();
    chk("t3_err_clr", 32'(err_tmo), 32'd0);

    // Read without data strobe
    mst_nodata = 1'b1;
    mst_word = 32'hFFFF_0000;
    v0 = valids;
    pulse_trig();
    wait_idle("t4");
    settle();
    chk("t4_err_nodata", 32'(err_nodata), 32'd1);
    chk("t4_valids", valids - v0, 0);
    chk("t4_cnt", 32'(sample_cnt), 32'd6);
    chk("t4_result", result, 32'h1234_5678);
    mst_nodata = 1'b0;

    // enable dropped mid-conversion, trig during read
    mst_word = 32'hCAFE_BABE;
    r0 = wr_rises; rr0 = rd_rises; v0 = valids;
    @(posedge clk); #1; enable = 1'b1;
    for (i = 0; i < P + 20; i++) begin
      @(posedge clk); #1;
      if (wr_rises > r0) break;
    end
    chk("t5_start_bound", 32'(i < P + 20), 32'd1);
    repeat (48) @(posedge clk); #1;
    enable = 1'b0;
    for (i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (rd_rises > rr0) break;
    end
    chk("t5_rd_bound", 32'(i < 100), 32'd1);
    repeat (10) @(posedge clk); #1;
    pulse_trig();
    wait_idle("t5");
    repeat (3 * P) @(posedge clk); #1;
    settle();
    chk("t5_wr_rises", wr_rises - r0, 1);
    chk("t5_valids", valids - v0, 1);
    chk("t5_cnt", 32'(sample_cnt), 32'd7);
    chk("t5_result", result, 32'hCAFE_BABE);

    // Asynchronous reset during write busy
    pulse_trig();
    repeat (10) @(posedge clk); #1;
    settle();
    chk("t6_pre_busy", 32'(seq_busy), 32'd1);
    @(negedge clk); #2;
    rstb = 1'b0;
    #1;
    chk("t6_m_wr", 32'(m_wr), 32'd0);
    chk("t6_m_rd", 32'(m_rd), 32'd0);
    chk("t6_seq_busy", 32'(seq_busy), 32'd0);
    chk("t6_result", result, 32'd0);
    chk("t6_valid", 32'(result_valid), 32'd0);
    chk("t6_cnt", 32'(sample_cnt), 32'd0);
    chk("t6_err_nodata", 32'(err_nodata), 32'd0);
    chk("t6_err_tmo", 32'(err_tmo), 32'd0);
    @(negedge clk); #2;
    rstb = 1'b1;
    repeat (5) @(posedge clk); #1;
    settle();
    chk("t6_post_idle", 32'(seq_busy), 32'd0);

    // Sample counter wrap
    mst_word = 32'hA1B2_C3D4;
    settle();
    force dut.r_sample_cnt = 16'hFFFF;
    e_cnt = 16'hFFFF;
    settle();
    release dut.r_sample_cnt;
    v0 = valids;
    pulse_trig();
    wait_idle("t7");
    settle();
    chk("t7_cnt_wrap", 32'(sample_cnt), 32'd0);
    chk("t7_valids", valids - v0, 1);
    chk("t7_result", result, 32'hA1B2_C3D4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
